line_buffer: RTL and testbench
==============================

LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 The block SHALL have one parameter: LINE_LEN, default 256, the number of active pixels per line.
REQ-002 The block SHALL have these ports, one per line, as name, direction, width, meaning:
- clk  in  1  pixel clock, one clock domain for the whole block.
- reset_n  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  the upstream core presents a pixel.
- wr_data  in  12  pixel as RGB444, with R in [11:8], G in [7:4], B in [3:0].
- wr_ready  out  1  the block accepts the pixel in this cycle.
- line_start  in  1  one-cycle pulse from the timing generator at the rising edge of h_act on active lines.
- rd_en  in  1  the timing generator is in active pixels (h_act && v_act).
- underflow_clr  in  1  synchronous clear of the underflow flag.
- VGA_R4  out  4  red to the timing/video stage.
- VGA_G4  out  4  green to the timing/video stage.
- VGA_B4  out  4  blue to the timing/video stage.
- underflow  out  1  sticky flag: a line was not ready at line_start.

Function
REQ-003 Storage SHALL be two banks of LINE_LEN x 12 bits; wr_bank selects the bank being written, and the read bank is ~wr_bank.
REQ-004 The writer FSM SHALL have two states, FILL and FULL.
REQ-005 In FILL, wr_ready SHALL be 1; in FULL, wr_ready SHALL be 0.
REQ-006 A write handshake (wr_valid && wr_ready) SHALL store wr_data at wr_addr and increment wr_addr.
REQ-007 A handshake at wr_addr = LINE_LEN-1 SHALL move the writer FILL->FULL, and wr_addr SHALL stay at LINE_LEN-1.
REQ-008 On line_start with the writer in FULL, the block SHALL do all of the following:
- toggle wr_bank;
- mark the new read bank valid;
- clear the new write bank's valid bit;
- set wr_addr=0 and rd_addr=0;
- move the writer to FILL.
REQ-009 On line_start with the writer in FILL (underflow), the block SHALL do all of the following:
- set underflow;
- leave wr_bank unchanged;
- set rd_addr=0, so the previous line replays;
- leave the writer's wr_addr and state unchanged.
REQ-010 When line_start and the final write handshake (wr_addr = LINE_LEN-1) occur in the same cycle, the block SHALL store the pixel and treat the line as FULL, so the swap of REQ-008 is taken.
REQ-011 While rd_en=1, rd_addr SHALL increment each cycle and wrap from LINE_LEN-1 to 0.
REQ-012 While rd_en=0, rd_addr SHALL hold, except for the line_start reload to 0.
REQ-013 Read latency SHALL be exactly 1 cycle: VGA_R4/G4/B4 in cycle n+1 reflect the RAM data addressed in cycle n when rd_en was 1.
REQ-014 VGA_R4/G4/B4 SHALL be 0 in the cycle after rd_en=0.
REQ-015 VGA_R4/G4/B4 SHALL be 0 when the read bank is not valid.
REQ-016 underflow_clr SHALL clear underflow; when underflow_clr and an underflow event occur in the same cycle, the set SHALL win.
REQ-017 line_start with rd_en=1 in the same cycle SHALL read address 0 in that cycle.

Reset
REQ-018 reset_n=0 SHALL asynchronously force the following, regardless of the operation in progress:
- VGA_R4/G4/B4 = 0;
- underflow = 0;
- wr_ready = 0;
- wr_bank = 0;
- wr_addr = 0 and rd_addr = 0;
- both bank-valid bits = 0;
- writer = FILL.
REQ-019 wr_ready SHALL go to 1 in the first cycle after reset_n rises.
REQ-020 RAM contents SHALL NOT be cleared by reset; bank-valid gating (REQ-015) SHALL hide stale data.
REQ-021 Reset asserted mid-line SHALL abandon any partial line; no write handshake SHALL complete while reset_n=0.

Structure
REQ-022 Shared package video_pkg SHALL hold the following, so the timing stage can share them:
- LINE_LEN default (256);
- typedef rgb444_t (12-bit packed R, G, B);
- enum wr_state_t {FILL, FULL}.
REQ-023 Storage SHALL be one sub-module, line_ram, with these properties:
- simple dual-port RAM of depth 2*LINE_LEN x 12;
- address MSB = bank;
- registered read port;
- one write port and one read port on clk.

Verification
REQ-024 Reset, then line_start with rd_en=1 for 256 cycles -> VGA_R4/G4/B4 = 0 throughout and underflow=1.
REQ-025 Write pixels 0x000..0x0FF -> wr_ready=0 after the 256th handshake. Then line_start and rd_en=1 for 256 cycles -> B4 output equals the pixel index low nibble, starting one cycle after rd_en rose.
REQ-026 Write only 100 pixels, then line_start -> underflow=1 and the previous line replays unchanged. After 156 more writes and the next line_start -> the new line displays.
REQ-027 Final (256th) handshake in the same cycle as line_start -> swap occurs, underflow stays 0, and the line displays completely.
REQ-028 Drop reset_n mid-line, after 50 reads and 80 writes -> outputs 0 immediately and wr_ready=0 during reset. wr_ready=1 one cycle after release, and the next line_start sets underflow.
REQ-029 underflow_clr in the same cycle as an underflow event -> underflow stays 1. Pulse underflow_clr alone -> underflow=0 next cycle.

Source files
------------

// File: rtl/video_pkg.sv
// Definitions shared between the line buffer and the video timing stage.
package video_pkg;

  localparam int DEFAULT_LINE_LEN = 256;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_t;

endpackage

// File: rtl/line_buffer_if.sv
// Pixel write channel from the upstream core into the line buffer.
interface line_buffer_if;
  import video_pkg::*;

  // valid/ready: a pixel transfers on a clk edge where wr_valid and wr_ready are
  // both 1; wr_data is held stable while wr_valid is 1, and wr_ready never
  // depends on wr_valid.
  logic    wr_valid;
  rgb444_t wr_data;
  logic    wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/line_ram.sv
// Simple dual-port line storage; the top address bit selects the bank.
module line_ram
  import video_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rgb444_t       wdata,
  input  logic [AW-1:0] raddr,
  output rgb444_t       rdata
);

  rgb444_t mem [0:(1<<AW)-1];

  // Contents are deliberately not reset; bank-valid gating hides stale lines.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_buffer.sv
// Ping-pong line buffer: the upstream core fills one bank while the video stage
// reads the other; banks swap on line_start once the write bank holds a full line.
module line_buffer
  import video_pkg::*;
#(
  parameter int LINE_LEN = DEFAULT_LINE_LEN
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_valid,
  input  logic [11:0] wr_data,
  output logic        wr_ready,
  input  logic        line_start,
  input  logic        rd_en,
  input  logic        underflow_clr,
  output logic [3:0]  VGA_R4,
  output logic [3:0]  VGA_G4,
  output logic [3:0]  VGA_B4,
  output logic        underflow
);

  localparam int IW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LINE_LEN - 1);

  line_buffer_if wr_if ();

  wr_state_t     state_q, state_d;
  logic          ready_q;
  logic          wr_bank_q;
  logic [1:0]    bank_vld_q;
  logic [IW-1:0] wr_addr_q, wr_addr_d;
  logic [IW-1:0] rd_addr_q, rd_addr_d;
  logic [IW-1:0] rd_idx;
  logic          out_en_q;
  logic          underflow_q;
  logic          wr_fire, last_fire, line_full, swap, under_evt;
  logic          rd_bank, rd_bank_vld;
  rgb444_t       ram_q;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IW'(1);
  endfunction

  assign wr_if.wr_valid = wr_valid;
  assign wr_if.wr_data  = wr_data;
  assign wr_if.wr_ready = ready_q && (state_q == FILL);
  assign wr_ready       = wr_if.wr_ready;

  assign wr_fire   = wr_if.wr_valid && wr_if.wr_ready;
  assign last_fire = wr_fire && (wr_addr_q == LAST_IDX);
  // The final pixel landing in the same cycle as line_start still counts as full.
  assign line_full = (state_q == FULL) || last_fire;
  assign swap      = line_start && line_full;
  assign under_evt = line_start && !line_full;

  // During a swap the bank being filled becomes the read bank in that same cycle.
  assign rd_bank     = swap ? wr_bank_q : ~wr_bank_q;
  assign rd_bank_vld = swap || bank_vld_q[rd_bank];
  assign rd_idx      = line_start ? '0 : rd_addr_q;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      FILL: begin
        if (last_fire) state_d = FULL;
        else if (wr_fire) wr_addr_d = next_idx(wr_addr_q);
      end
      FULL: begin
        state_d = FULL;
      end
    endcase
    if (swap) begin
      state_d   = FILL;
      wr_addr_d = '0;
    end
    if (rd_en) rd_addr_d = next_idx(rd_idx);
    else if (line_start) rd_addr_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FILL;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q     <= 1'b0;
      wr_bank_q   <= 1'b0;
      bank_vld_q  <= 2'b00;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      out_en_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      out_en_q  <= rd_en && rd_bank_vld;
      if (swap) begin
        wr_bank_q              <= ~wr_bank_q;
        bank_vld_q[wr_bank_q]  <= 1'b1;
        bank_vld_q[~wr_bank_q] <= 1'b0;
      end
      if (under_evt)          underflow_q <= 1'b1;
      else if (underflow_clr) underflow_q <= 1'b0;
    end
  end

  line_ram #(.AW(IW + 1)) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wr_bank_q, wr_addr_q}),
    .wdata (wr_if.wr_data),
    .raddr ({rd_bank, rd_idx}),
    .rdata (ram_q)
  );

  assign VGA_R4    = out_en_q ? ram_q.r : 4'h0;
  assign VGA_G4    = out_en_q ? ram_q.g : 4'h0;
  assign VGA_B4    = out_en_q ? ram_q.b : 4'h0;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_line_buffer.sv
// Directed scenarios for line_buffer with a scoreboard on the video outputs.
module tb_line_buffer;
  import video_pkg::*;

  localparam int L = 256;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       line_start;
  logic       rd_en;
  logic       underflow_clr;
  logic [3:0] r4, g4, b4;
  logic       underflow;

  line_buffer_if pix_if ();

  always #5 clk = ~clk;

  line_buffer #(.LINE_LEN(L)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_valid      (pix_if.wr_valid),
    .wr_data       (pix_if.wr_data),
    .wr_ready      (pix_if.wr_ready),
    .line_start    (line_start),
    .rd_en         (rd_en),
    .underflow_clr (underflow_clr),
    .VGA_R4        (r4),
    .VGA_G4        (g4),
    .VGA_B4        (b4),
    .underflow     (underflow)
  );

  logic [11:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  logic [11:0] pend [L];
  logic [11:0] disp [L];
  bit          disp_ok;
  int          rd_ptr;
  int          wr_cnt;
  logic [3:0]  seed;

  function automatic logic [11:0] pix(input logic [3:0] s, input int i);
    logic [7:0] lo;
    lo = i[7:0];
    return {s, lo};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: output in cycle n+1 reflects the read issued in cycle n.
  logic        rd_en_d = 1'b0;
  logic [11:0] mon_exp;
  always @(posedge clk) rd_en_d <= rd_en;
  always @(negedge clk) begin
    if (rd_en_d === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underrun: got 0x%0h with no expected pixel", {r4, g4, b4});
      end else begin
        mon_exp = exp_q.pop_front();
        check("pixel", {20'h0, r4, g4, b4}, {20'h0, mon_exp});
      end
    end else begin
      check("blank", {20'h0, r4, g4, b4}, 32'h0);
    end
  end

  // One clock of stimulus; sw marks a line_start the scenario expects to swap banks.
  task automatic cycle(input bit ls, input bit rd, input bit wv, input bit sw, input bit clr);
    bit hs;
    line_start      = ls;
    rd_en           = rd;
    underflow_clr   = clr;
    pix_if.wr_valid = wv;
    pix_if.wr_data  = pix(seed, wr_cnt);
    hs = wv && (pix_if.wr_ready === 1'b1);
    if (hs) pend[wr_cnt] = pix(seed, wr_cnt);
    if (sw) begin
      disp    = pend;
      disp_ok = 1'b1;
    end
    if (ls) rd_ptr = 0;
    if (rd) begin
      exp_q.push_back(disp_ok ? disp[rd_ptr] : 12'h000);
      rd_ptr = (rd_ptr + 1) % L;
    end
    if (sw) wr_cnt = 0;
    else if (hs) wr_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic write_line(input int n);
    int budget = 0;
    int target = wr_cnt + n;
    while (wr_cnt < target && budget < 4 * n + 8) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      budget++;
    end
    pix_if.wr_valid = 1'b0;
    check("write_count", wr_cnt, target);
  endtask

  task automatic read_line(input int n, input bit sw, input bit clr);
    cycle(1'b1, 1'b1, 1'b0, sw, clr);
    for (int i = 1; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; line_start = 1'b0; rd_en = 1'b0; underflow_clr = 1'b0;
    pix_if.wr_valid = 1'b0; pix_if.wr_data = '0;
    seed = 4'h0; wr_cnt = 0; rd_ptr = 0; disp_ok = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_ready", pix_if.wr_ready, 0);
    check("reset_underflow", underflow, 0);
    check("reset_rgb", {r4, g4, b4}, 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    check("ready_before_edge", pix_if.wr_ready, 0);
    @(posedge clk);
    #1;
    check("ready_after_release", pix_if.wr_ready, 1);

    // Empty buffer at the first line: black output and underflow.
    read_line(L, 1'b0, 1'b0);
    check("underflow_empty", underflow, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("underflow_clr_alone", underflow, 0);

    // Full line 0x000..0x0FF, then display it.
    seed = 4'h0;
    write_line(L);
    check("ready_when_full", pix_if.wr_ready, 0);
    check("no_underflow_fill", underflow, 0);
    read_line(L, 1'b1, 1'b0);
    check("underflow_after_swap", underflow, 0);
    check("ready_after_swap", pix_if.wr_ready, 1);

    // Partial line: underflow and replay, then complete it and display.
    seed = 4'h3;
    write_line(100);
    check("ready_partial", pix_if.wr_ready, 1);
    read_line(L, 1'b0, 1'b0);
    check("underflow_partial", underflow, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("underflow_cleared", underflow, 0);
    write_line(L - 100);
    check("ready_completed", pix_if.wr_ready, 0);
    read_line(L, 1'b1, 1'b0);
    check("underflow_completed", underflow, 0);

    // Final handshake coincides with line_start.
    seed = 4'h7;
    write_line(L - 1);
    check("ready_before_last", pix_if.wr_ready, 1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < L; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("underflow_same_cycle", underflow, 0);
    check("ready_same_cycle", pix_if.wr_ready, 1);

    // Reset mid-line after 80 writes and 50 reads.
    seed = 4'hC;
    write_line(L);
    seed = 4'h5;
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 80; i++) cycle(1'b0, i >= 31, 1'b1, 1'b0, 1'b0);
    check("writes_before_reset", wr_cnt, 80);
    rd_en = 1'b0;
    @(negedge clk);
    #1;
    check("rgb_before_reset", {r4, g4, b4}, pix(4'hC, 49));
    reset_n = 1'b0;
    #1;
    check("rgb_async_reset", {r4, g4, b4}, 0);
    check("ready_in_reset", pix_if.wr_ready, 0);
    disp_ok = 1'b0;
    wr_cnt  = 0;
    repeat (3) @(posedge clk);
    #1;
    check("ready_held_in_reset", pix_if.wr_ready, 0);
    pix_if.wr_valid = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset2", pix_if.wr_ready, 1);

    // line_start after reset underflows; clear in the same cycle loses.
    read_line(L, 1'b0, 1'b1);
    check("underflow_set_wins", underflow, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("underflow_clr_final", underflow, 0);

    // Recovery: a fresh full line displays.
    seed = 4'h9;
    write_line(L);
    read_line(L, 1'b1, 1'b0);
    check("underflow_recovered", underflow, 0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
